// File: rtl/joybus_host_transceiver.sv
// Console-side Joybus initiator: sends a command byte plus console STOP on an open-drain line,
// then decodes a 0-4 byte controller reply terminated by the controller STOP bit.
module joybus_host_transceiver #(
    parameter int LEVEL_WIDTH = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [2:0]  rsp_len,
    input  logic        data_rx,
    output logic        data_tx_oe,
    output logic        busy,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    output logic        rsp_err
);

    localparam int LVL_W  = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
    localparam int LOW_W  = $clog2(4*LEVEL_WIDTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVEL_WIDTH - 1);
    localparam logic [LOW_W-1:0]  LOW_ONE   = LOW_W'(2*LEVEL_WIDTH);
    localparam logic [LOW_W-1:0]  LOW_STUCK = LOW_W'(4*LEVEL_WIDTH - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX_BIT, S_TX_STOP, S_RX_WAIT_FALL, S_RX_LOW, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [2:0]         len_q, len_d;
    logic [LVL_W-1:0]   lvl_cnt_q, lvl_cnt_d;
    logic [1:0]         lvl_idx_q, lvl_idx_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;
    logic               oe_q, oe_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic               line;
    logic               fall;
    logic               tx_bit;
    logic [2:0]         len_clamped;
    logic [5:0]         nbits;

    assign line  = sync_q[1];
    assign fall  = prev_q & ~line;
    assign nbits = {len_q, 3'b000};

    // Synchroniser flops idle at the released (high) level so reset never fakes a falling edge.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], data_rx};
            prev_q <= line;
        end
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            lvl_cnt_q  <= '0;
            lvl_idx_q  <= '0;
            bit_idx_q  <= '0;
            idle_cnt_q <= '0;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            lvl_cnt_q  <= lvl_cnt_d;
            lvl_idx_q  <= lvl_idx_d;
            bit_idx_q  <= bit_idx_d;
            idle_cnt_q <= idle_cnt_d;
            low_cnt_q  <= low_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        lvl_cnt_d   = lvl_cnt_q;
        lvl_idx_d   = lvl_idx_q;
        bit_idx_d   = bit_idx_q;
        idle_cnt_d  = idle_cnt_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        oe_d        = 1'b0;
        tx_bit      = 1'b0;
        len_clamped = (rsp_len > 3'd4) ? 3'd4 : rsp_len;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_TX_BIT;
                    cmd_d      = cmd;
                    len_d      = len_clamped;
                    lvl_cnt_d  = '0;
                    lvl_idx_d  = '0;
                    bit_idx_d  = '0;
                    idle_cnt_d = '0;
                    bit_cnt_d  = '0;
                    rsp_data_d = '0;
                    busy_d     = 1'b1;
                end
            end
            // TX walks (bit, level, cycle-in-level); lvl_idx and bit_idx wrap to 0 entering STOP.
            S_TX_BIT, S_TX_STOP: begin
                if (lvl_cnt_q == LVL_LAST) begin
                    lvl_cnt_d = '0;
                    lvl_idx_d = lvl_idx_q + 2'd1;
                    if (state_q == S_TX_BIT && lvl_idx_q == 2'd3) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7)
                            state_d = S_TX_STOP;
                    end else if (state_q == S_TX_STOP && lvl_idx_q == 2'd2) begin
                        lvl_idx_d  = '0;
                        idle_cnt_d = '0;
                        if (len_q == 3'd0) begin
                            state_d = S_DONE;
                            valid_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_RX_WAIT_FALL;
                        end
                    end
                end else begin
                    lvl_cnt_d = lvl_cnt_q + 1'b1;
                end
            end
            S_RX_WAIT_FALL: begin
                if (fall) begin
                    state_d    = S_RX_LOW;
                    low_cnt_d  = LOW_W'(1);
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_RX_LOW: begin
                if (line) begin
                    if (bit_cnt_q == nbits) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        rsp_data_d = {rsp_data_q[30:0], (low_cnt_q < LOW_ONE)};
                        bit_cnt_d  = bit_cnt_q + 6'd1;
                        idle_cnt_d = '0;
                        state_d    = S_RX_WAIT_FALL;
                    end
                end else if (low_cnt_q == LOW_STUCK) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // oe is registered from the next position, so the first low appears the cycle after start.
        tx_bit = cmd_d[3'd7 - bit_idx_d];
        if (state_d == S_TX_BIT)
            oe_d = tx_bit ? (lvl_idx_d == 2'd0) : (lvl_idx_d != 2'd3);
        else if (state_d == S_TX_STOP)
            oe_d = (lvl_idx_d == 2'd0);
    end

    assign data_tx_oe = oe_q;
    assign busy       = busy_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_valid  = valid_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_joybus_host_transceiver.sv
// Randomised scoreboard bench: a bench-side controller model answers on the shared line,
// expected responses are queued at start and checked by an independent monitor.
module tb_joybus_host_transceiver;

    localparam int L  = 2;
    localparam int TO = 64;

    logic        sample_clk;
    logic        reset;
    logic        start;
    logic [7:0]  cmd;
    logic [2:0]  rsp_len;
    logic        data_rx;
    logic        data_tx_oe;
    logic        busy;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic        ctrl_oe;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]  kind;   // {valid, err}
        logic [31:0] data;
        int          at;     // expected pulse cycle, -1 = don't care
    } exp_t;
    exp_t exp_q[$];

    joybus_host_transceiver #(.LEVEL_WIDTH(L), .TIMEOUT(TO)) dut (
        .sample_clk (sample_clk),
        .reset      (reset),
        .start      (start),
        .cmd        (cmd),
        .rsp_len    (rsp_len),
        .data_rx    (data_rx),
        .data_tx_oe (data_tx_oe),
        .busy       (busy),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err)
    );

    // Wired-AND open-drain line with pull-up.
    assign data_rx = ~(data_tx_oe | ctrl_oe);

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;
    always @(posedge sample_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    // Expected line drive at cycle p after the accepting edge, straight from the bit encoding.
    function automatic logic exp_oe(input logic [7:0] c, input int p);
        int lvl;
        if (p < 32*L) begin
            lvl = (p % (4*L)) / L;
            return c[7 - p/(4*L)] ? (lvl == 0) : (lvl < 3);
        end else if (p < 35*L) begin
            return ((p - 32*L) / L) == 0;
        end
        return 1'b0;
    endfunction

    task automatic check_oe(input logic [7:0] c, input int a);
        int bad = 0;
        for (int p = 0; p < 35*L + 20; p++) begin
            @(negedge sample_clk);
            if (data_tx_oe !== exp_oe(c, cyc - a)) bad++;
        end
        chk("oe_wave", bad, 0);
    endtask

    task automatic drive_reply(input int a, input logic [31:0] v, input int nb, input int mode);
        int low;
        if (mode == 1 || nb == 0) return;
        while (cyc < a + 35*L) tick();
        repeat ($urandom_range(0, 16)) tick();
        for (int i = nb - 1; i >= 0; i--) begin
            if (mode == 2 && i == nb - 6) begin
                ctrl_oe = 1'b1;
                repeat (4*L) tick();
                ctrl_oe = 1'b0;
                return;
            end
            low = v[i] ? L : 3*L;
            ctrl_oe = 1'b1;
            repeat (low) tick();
            ctrl_oe = 1'b0;
            repeat (4*L - low) tick();
        end
        ctrl_oe = 1'b1;
        repeat (2*L) tick();
        ctrl_oe = 1'b0;
    endtask

    // mode: 0 normal reply, 1 silent controller, 2 reply bit 5 stuck low
    task automatic run_txn(input logic [7:0] c, input logic [2:0] len, input logic [31:0] val,
                           input int mode, input bit dup);
        int nb, a;
        logic [31:0] v;
        exp_t e;
        nb = ((len > 3'd4) ? 4 : int'(len)) * 8;
        v  = (nb == 32) ? val : (val & ((32'd1 << nb) - 32'd1));
        start = 1'b1; cmd = c; rsp_len = len;
        tick();
        start = 1'b0;
        a = cyc;
        if (nb == 0)        e = '{2'b10, 32'd0, a + 35*L};
        else if (mode == 1) e = '{2'b01, 32'd0, a + 35*L + TO};
        else if (mode == 2) e = '{2'b01, v >> (nb - 5), -1};
        else                e = '{2'b10, v, -1};
        exp_q.push_back(e);
        fork
            check_oe(c, a);
            drive_reply(a, v, nb, mode);
            begin
                if (dup) begin
                    repeat (30) tick();
                    start = 1'b1; cmd = ~c; rsp_len = 3'd2;
                    tick();
                    start = 1'b0;
                end
            end
        join
        for (int i = 0; i < 400 && busy; i++) tick();
        chk("idle_after", busy, 0);
        repeat (4) tick();
        chk("rsp_hold", rsp_data, e.data);
    endtask

    always @(negedge sample_clk) begin
        exp_t e;
        if (!reset && (rsp_valid || rsp_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none (cycle %0d)",
                         rsp_valid, rsp_err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_kind", {rsp_valid, rsp_err}, e.kind);
                chk("rsp_data", rsp_data, e.data);
                chk("busy_at_done", busy, 0);
                if (e.at >= 0) chk("rsp_time", cyc, e.at);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; cmd = '0; rsp_len = '0; ctrl_oe = 1'b0;
        repeat (3) tick();
        chk("rst_oe", data_tx_oe, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        chk("rst_state", {busy, rsp_valid, rsp_err, data_tx_oe, rsp_data}, 0);

        run_txn(8'h01, 3'd4, 32'h0000_0000, 0, 1'b0);
        run_txn(8'h00, 3'd3, 32'h0005_0000, 0, 1'b0);
        run_txn(8'h01, 3'd4, 32'h0,         1, 1'b0);
        run_txn(8'h01, 3'd4, 32'hD5A5_1234, 2, 1'b0);
        run_txn(8'hA6, 3'd0, 32'h0,         0, 1'b1);
        run_txn(8'h5C, 3'd4, 32'hFFFF_FFFF, 0, 1'b1);

        // Reset pulsed during command bit 3.
        start = 1'b1; cmd = 8'h00; rsp_len = 3'd4;
        tick();
        start = 1'b0;
        repeat (12*L + 1) tick();
        chk("pre_rst_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_oe", data_tx_oe, 0);
        chk("midrst_busy", busy, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        run_txn(8'h01, 3'd2, 32'h0000_8001, 0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            logic [2:0] len;
            len = 3'($urandom_range(0, 7));
            run_txn(8'($urandom), len, $urandom,
                    ($urandom_range(0, 5) == 0) ? 1 : 0, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
